ro_heater_modulator: RTL and testbench

- Sequencer for the covert-channel transmitter. Drives the enable inputs of a bank of ring-oscillator heater instances.
- Sends a fixed-length frame as on-off keying: bit 1 means the masked heater banks are on for one bit period; bit 0 means all banks are off.
- Ends each frame with a guard (cool-down) interval with all heaters off, then pulses done.
- Sits between the host-facing control registers and the heater array.

---
 rtl/ro_heater_modulator.sv | 157 +++++++++++++++
 tb/tb_ro_heater_modulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ro_heater_modulator.sv
// ro_heater_modulator: on-off keying sequencer for a bank of ring-oscillator heaters.
// Sends a latched frame MSB first, then a forced-off guard interval, then pulses done.
module ro_heater_modulator #(
    parameter int NUM_BANKS  = 8,
    parameter int FRAME_BITS = 32,
    parameter int PERIOD_W   = 32,
    localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [FRAME_BITS-1:0] frame_data,
    input  logic [PERIOD_W-1:0]   bit_period,
    input  logic [PERIOD_W-1:0]   guard_period,
    input  logic [NUM_BANKS-1:0]  bank_mask,
    output logic [NUM_BANKS-1:0]  heater_en,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [IW-1:0]         bit_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [IW-1:0]       LAST = IW'(FRAME_BITS - 1);
    localparam logic [PERIOD_W-1:0] ONE  = PERIOD_W'(1);

    state_t                state, state_n;
    logic [NUM_BANKS-1:0]  heat_n;
    logic                  busy_n, done_n, err_n;
    logic [IW-1:0]         idx_n;
    logic [PERIOD_W-1:0]   cnt, cnt_n;
    logic [FRAME_BITS-1:0] data_q, data_n, shifted;
    logic [PERIOD_W-1:0]   p_q, p_n, g_q, g_n;
    logic [NUM_BANKS-1:0]  mask_q, mask_n;

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        state_n = state;
        heat_n  = heater_en;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        idx_n   = bit_index;
        cnt_n   = cnt;
        data_n  = data_q;
        p_n     = p_q;
        g_n     = g_q;
        mask_n  = mask_q;
        shifted = data_q << 1;
        if (abort) begin
            state_n = IDLE;
            heat_n  = '0;
            busy_n  = 1'b0;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (bit_period != '0) begin
                            data_n  = frame_data;
                            p_n     = bit_period;
                            g_n     = guard_period;
                            mask_n  = bank_mask;
                            state_n = SEND;
                            busy_n  = 1'b1;
                            idx_n   = '0;
                            cnt_n   = '0;
                            heat_n  = bank_mask
                                    & {NUM_BANKS{frame_data[FRAME_BITS-1]}};
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (cnt == p_q - ONE) begin
                        cnt_n = '0;
                        if (bit_index == LAST) begin
                            heat_n = '0;
                            idx_n  = '0;
                            if (g_q != '0) begin
                                state_n = GUARD;
                            end else begin
                                state_n = IDLE;
                                busy_n  = 1'b0;
                                done_n  = 1'b1;
                            end
                        end else begin
                            idx_n  = bit_index + 1'b1;
                            data_n = shifted;
                            heat_n = mask_q
                                   & {NUM_BANKS{shifted[FRAME_BITS-1]}};
                        end
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                GUARD: begin
                    heat_n = '0;
                    if (cnt == g_q - ONE) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    heat_n  = '0;
                    busy_n  = 1'b0;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State, outputs and latched frame settings; reset forces heaters off at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            heater_en <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            bit_index <= '0;
            cnt       <= '0;
            data_q    <= '0;
            p_q       <= '0;
            g_q       <= '0;
            mask_q    <= '0;
        end else begin
            state     <= state_n;
            heater_en <= heat_n;
            busy      <= busy_n;
            done      <= done_n;
            cfg_err   <= err_n;
            bit_index <= idx_n;
            cnt       <= cnt_n;
            data_q    <= data_n;
            p_q       <= p_n;
            g_q       <= g_n;
            mask_q    <= mask_n;
        end
    end

endmodule

// File: tb/tb_ro_heater_modulator.sv
// tb_ro_heater_modulator: directed frame vectors plus abort, reset,
// config-error, mid-frame disturbance and back-to-back sequences.
module tb_ro_heater_modulator;

    typedef struct {
        logic [31:0] data;
        logic [31:0] p;
        logic [31:0] g;
        logic [7:0]  mask;
        int          exp_busy;
        int          exp_on;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] frame_data;
    logic [31:0] bit_period;
    logic [31:0] guard_period;
    logic [7:0]  bank_mask;
    logic [7:0]  heater_en;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [4:0]  bit_index;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t v[5];

    ro_heater_modulator #(
        .NUM_BANKS(8),
        .FRAME_BITS(32),
        .PERIOD_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .frame_data(frame_data),
        .bit_period(bit_period),
        .guard_period(guard_period),
        .bank_mask(bank_mask),
        .heater_en(heater_en),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err),
        .bit_index(bit_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input vec_t r);
        frame_data   = r.data;
        bit_period   = r.p;
        guard_period = r.g;
        bank_mask    = r.mask;
    endtask

    task automatic launch(input vec_t r);
        set_inputs(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_frame(input vec_t r, input bit disturb,
                               input bit chain, input vec_t nx);
        int on;
        int b;
        logic [7:0] eh;
        on = 0;
        for (int k = 0; k < r.exp_busy; k++) begin
            b  = k / int'(r.p);
            eh = (b < 32 && r.data[31-b]) ? r.mask : 8'h00;
            chk("busy", busy, 1);
            chk("heater_en", heater_en, eh);
            chk("done_low", done, 0);
            if (b < 32) chk("bit_index", bit_index, b);
            if (heater_en != 8'h00) on++;
            if (disturb && k == 20) begin
                bank_mask    = 8'h01;
                frame_data   = 32'h0;
                bit_period   = 32'd1;
                guard_period = 32'd0;
                start        = 1'b1;
            end
            if (disturb && k == 23) start = 1'b0;
            @(negedge clk);
        end
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("heater_end", heater_en, 0);
        chk("index_end", bit_index, 0);
        chk("on_cycles", on, r.exp_on);
        if (chain) begin
            launch(nx);
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 0);
        end
    endtask

    initial begin
        v[0] = '{32'hA5000001, 32'd4, 32'd8, 8'hFF, 136, 20};
        v[1] = '{32'hFFFFFFFF, 32'd1, 32'd0, 8'h0F, 32, 32};
        v[2] = '{32'h00000000, 32'd2, 32'd3, 8'hFF, 67, 0};
        v[3] = '{32'h80000000, 32'd3, 32'd1, 8'h00, 97, 0};
        v[4] = '{32'h00000001, 32'd1, 32'd2, 8'h3C, 34, 1};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_inputs(v[0]);
        repeat (3) @(negedge clk);
        chk("rst_heater", heater_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_index", bit_index, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            launch(v[i]);
            check_frame(v[i], 1'b0, 1'b0, v[i]);
        end

        bit_period = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err", cfg_err, 1);
        chk("err_busy", busy, 0);
        chk("err_heater", heater_en, 0);
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 0);
        chk("err_busy2", busy, 0);

        launch(v[0]);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_heater", heater_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_index", bit_index, 0);
        chk("abort_done", done, 0);
        set_inputs(v[0]);
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_done", done, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        launch(v[1]);
        check_frame(v[1], 1'b0, 1'b0, v[1]);

        launch(v[0]);
        check_frame(v[0], 1'b1, 1'b1, v[4]);
        check_frame(v[4], 1'b0, 1'b0, v[4]);

        launch(v[0]);
        repeat (9) @(negedge clk);
        chk("pre_rst_heater", heater_en, 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("async_heater", heater_en, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_heater", heater_en, 0);
        launch(v[1]);
        check_frame(v[1], 1'b0, 1'b0, v[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
